// File: rtl/sw_feeder.sv
// Sequence feeder for a Smith-Waterman style aligner: holds two packed base
// sequences, streams them out one base pair per cycle, then waits for the score.
module sw_feeder #(
    parameter int SEQ_LEN = 256,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [5:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] result,
    output logic        valid,
    output logic [1:0]  data_s,
    output logic [1:0]  data_t,
    input  logic        finish,
    input  logic [11:0] max
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [11:0] WAIT_LAST = 12'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [11:0]      wait_cnt_reg, wait_cnt_next;
    logic             valid_reg, valid_next;
    logic [1:0]       data_s_reg, data_s_next;
    logic [1:0]       data_t_reg, data_t_next;
    logic [11:0]      result_reg, result_next;
    logic             error_reg, error_next;

    logic [1:0] mem_s [SEQ_LEN];
    logic [1:0] mem_t [SEQ_LEN];

    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx [4];
    logic [IDX_W-1:0] rd_idx;
    logic             bypass;
    logic [1:0]       rd_s;
    logic [1:0]       rd_t;

    // Out-of-range addresses must not alias onto valid bytes, so range is
    // checked on the full address before truncation.
    assign wr_ok = wr_en && (state_reg == IDLE) && (32'(wr_addr) < SEQ_LEN / 4);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_idx[k] = IDX_W'({wr_addr, 2'(k)});
        end
    end

    // Sequence storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_sel) begin
                    mem_t[wr_idx[k]] <= wr_data[2*k +: 2];
                end else begin
                    mem_s[wr_idx[k]] <= wr_data[2*k +: 2];
                end
            end
        end
    end

    // In IDLE the next base fetched is index 0; a write to byte 0 in the same
    // cycle as start is forwarded so the stream sees the new data.
    assign rd_idx = (state_reg == STREAM) ? idx_reg + 1'b1 : '0;
    assign bypass = wr_ok && (wr_addr == 6'd0);
    assign rd_s   = (bypass && !wr_sel) ? wr_data[1:0] : mem_s[rd_idx];
    assign rd_t   = (bypass &&  wr_sel) ? wr_data[1:0] : mem_t[rd_idx];

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        valid_next    = 1'b0;
        data_s_next   = 2'd0;
        data_t_next   = 2'd0;
        result_next   = result_reg;
        error_next    = error_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = STREAM;
                    idx_next    = '0;
                    valid_next  = 1'b1;
                    data_s_next = rd_s;
                    data_t_next = rd_t;
                    error_next  = 1'b0;
                end
            end
            STREAM: begin
                if (idx_reg == LAST_IDX) begin
                    state_next    = WAIT;
                    wait_cnt_next = 12'd0;
                end else begin
                    idx_next    = idx_reg + 1'b1;
                    valid_next  = 1'b1;
                    data_s_next = rd_s;
                    data_t_next = rd_t;
                end
            end
            WAIT: begin
                // A finish arriving on the timeout cycle still wins.
                if (finish) begin
                    result_next = max;
                    error_next  = 1'b0;
                    state_next  = DONE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    result_next = 12'd0;
                    error_next  = 1'b1;
                    state_next  = DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 12'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            wait_cnt_reg <= 12'd0;
            valid_reg    <= 1'b0;
            data_s_reg   <= 2'd0;
            data_t_reg   <= 2'd0;
            result_reg   <= 12'd0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            valid_reg    <= valid_next;
            data_s_reg   <= data_s_next;
            data_t_reg   <= data_t_next;
            result_reg   <= result_next;
            error_reg    <= error_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign error  = error_reg;
    assign result = result_reg;
    assign valid  = valid_reg;
    assign data_s = data_s_reg;
    assign data_t = data_t_reg;

endmodule

// File: tb/tb_sw_feeder.sv
// Scoreboard bench for sw_feeder: a full-size instance and a short-timeout
// instance share one expected-beat queue and one expected-completion queue.
module tb_sw_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_en_v;
    logic [1:0]  start_v;
    logic        wr_sel;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        finish;
    logic [11:0] max_in;

    logic [1:0]  busy_v, done_v, error_v, valid_v;
    logic [11:0] result_v [2];
    logic [1:0]  ds_v [2];
    logic [1:0]  dt_v [2];

    always #5 clk = ~clk;

    sw_feeder #(.SEQ_LEN(256), .TIMEOUT(4095)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_v[0]), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
        .result(result_v[0]), .valid(valid_v[0]), .data_s(ds_v[0]), .data_t(dt_v[0]),
        .finish(finish), .max(max_in)
    );

    sw_feeder #(.SEQ_LEN(16), .TIMEOUT(16)) dut_to (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_v[1]), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
        .result(result_v[1]), .valid(valid_v[1]), .data_s(ds_v[1]), .data_t(dt_v[1]),
        .finish(finish), .max(max_in)
    );

    typedef struct {
        int         inst;
        int         idx;
        logic [1:0] s;
        logic [1:0] t;
    } beat_t;

    typedef struct {
        int          inst;
        logic [11:0] res;
        logic        err;
        int          wc;
    } end_t;

    beat_t beat_q[$];
    end_t  end_q[$];
    beat_t mb;
    end_t  me;
    int    n_vec = 0;
    int    n_err = 0;
    int    wcnt [2];

    logic [1:0] m_s [2][256];
    logic [1:0] m_t [2][256];

    function automatic int seqn(input int inst);
        return (inst == 0) ? 256 : 16;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_wr(input int inst, input logic sel,
                                     input logic [5:0] a, input logic [7:0] d);
        if (int'(a) < seqn(inst) / 4) begin
            for (int k = 0; k < 4; k++) begin
                if (sel) m_t[inst][int'(a) * 4 + k] = d[2*k +: 2];
                else     m_s[inst][int'(a) * 4 + k] = d[2*k +: 2];
            end
        end
    endfunction

    task automatic wr(input int inst, input logic sel, input logic [5:0] a, input logic [7:0] d);
        wr_en_v[inst] = 1'b1;
        wr_sel  = sel;
        wr_addr = a;
        wr_data = d;
        model_wr(inst, sel, a, d);
        @(negedge clk);
        wr_en_v = '0;
    endtask

    task automatic push_beats(input int inst);
        for (int i = 0; i < seqn(inst); i++) begin
            beat_q.push_back('{inst, i, m_s[inst][i], m_t[inst][i]});
        end
    endtask

    // One alignment run. fin_after<0 means finish is never raised (timeout).
    // wr_mid/fin_mid/start_mid are negedge numbers after start for disturbances.
    task automatic run(input int inst, input int fin_after, input logic [11:0] mx,
                       input int wr_mid, input int fin_mid, input int start_mid,
                       input bit co_wr, input logic [7:0] co_data);
        int n, cur, limit;
        n = seqn(inst);
        if (co_wr) begin
            model_wr(inst, 1'b0, 6'd0, co_data);
            wr_en_v[inst] = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = 6'd0;
            wr_data = co_data;
        end
        push_beats(inst);
        if (fin_after >= 0) end_q.push_back('{inst, mx, 1'b0, fin_after});
        else                end_q.push_back('{inst, 12'd0, 1'b1, (inst == 0) ? 4095 : 16});
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v = '0;
        wr_en_v = '0;
        check("busy_after_start", busy_v[inst], 1);
        check("error_clear_on_start", error_v[inst], 0);
        cur   = 1;
        limit = (fin_after >= 0) ? n + fin_after : n + ((inst == 0) ? 4095 : 16) + 2;
        while (cur < limit) begin
            if (cur == fin_mid) begin
                finish = 1'b1;
                max_in = 12'hFFF;
            end
            if (cur == wr_mid) begin
                wr_en_v[inst] = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 6'd0;
                wr_data = 8'hFF;
            end
            if (cur == start_mid) start_v[inst] = 1'b1;
            @(negedge clk);
            finish  = 1'b0;
            wr_en_v = '0;
            start_v = '0;
            cur++;
        end
        if (fin_after >= 0) begin
            max_in = mx;
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: consumes expected beats on valid and completions on done.
    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (valid_v[i]) begin
                    if (beat_q.size() == 0) begin
                        check($sformatf("unexpected_valid_inst%0d", i), 1, 0);
                    end else begin
                        mb = beat_q.pop_front();
                        check("beat_inst", i, mb.inst);
                        check($sformatf("data_s[%0d]", mb.idx), ds_v[i], mb.s);
                        check($sformatf("data_t[%0d]", mb.idx), dt_v[i], mb.t);
                    end
                    wcnt[i] = 0;
                end else begin
                    if (busy_v[i]) check("data_zero_when_invalid", {ds_v[i], dt_v[i]}, 0);
                    if (busy_v[i] && !done_v[i]) wcnt[i]++;
                    if (done_v[i]) begin
                        if (end_q.size() == 0) begin
                            check($sformatf("unexpected_done_inst%0d", i), 1, 0);
                        end else begin
                            me = end_q.pop_front();
                            check("done_inst", i, me.inst);
                            check("result", result_v[i], me.res);
                            check("error", error_v[i], me.err);
                            check("wait_cycles", wcnt[i], me.wc);
                            check("beats_left_at_done", beat_q.size(), 0);
                            $display("run inst=%0d result=%03h error=%0b wait=%0d",
                                     i, result_v[i], error_v[i], wcnt[i]);
                        end
                        wcnt[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        wr_en_v = '0;
        start_v = '0;
        wr_sel  = 1'b0;
        wr_addr = 6'd0;
        wr_data = 8'd0;
        finish  = 1'b0;
        max_in  = 12'd0;
        wcnt[0] = 0;
        wcnt[1] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", busy_v[i], 0);
            check("reset_done", done_v[i], 0);
            check("reset_error", error_v[i], 0);
            check("reset_result", result_v[i], 0);
            check("reset_valid", valid_v[i], 0);
            check("reset_data", {ds_v[i], dt_v[i]}, 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // All-zero sequences, finish after 20 WAIT cycles.
        for (int a = 0; a < 64; a++) begin
            wr(0, 1'b0, 6'(a), 8'h00);
            wr(0, 1'b1, 6'(a), 8'h00);
        end
        run(0, 20, 12'd512, -1, -1, -1, 1'b0, 8'h00);

        // Patterned image; byte 0 of S rewritten to E4 in the start cycle.
        for (int a = 0; a < 64; a++) begin
            wr(0, 1'b0, 6'(a), 8'(a * 29 + 7));
            wr(0, 1'b1, 6'(a), ~8'(a * 13));
        end
        run(0, 5, 12'h0AB, -1, -1, -1, 1'b1, 8'hE4);

        // finish pulsed mid-stream with max=FFF must be ignored.
        run(0, 7, 12'h321, -1, 50, -1, 1'b0, 8'h00);

        // Write during STREAM and start during WAIT are dropped; second run re-reads storage.
        run(0, 10, 12'h456, 30, -1, 259, 1'b0, 8'h00);
        run(0, 3, 12'h00C, -1, -1, -1, 1'b0, 8'h00);

        // Reset while index 100 is on the bus.
        push_beats(0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_valid", valid_v[0], 0);
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_result", result_v[0], 0);
        check("abort_beats_left", beat_q.size(), 256 - 101);
        beat_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_abort_idle", busy_v[0], 0);
        run(0, 4, 12'h9C3, -1, -1, -1, 1'b0, 8'h00);

        // Short instance: out-of-range writes dropped, then normal, timeout, recovery.
        wr(1, 1'b0, 6'd0, 8'h1B);
        wr(1, 1'b0, 6'd1, 8'hE4);
        wr(1, 1'b0, 6'd2, 8'h72);
        wr(1, 1'b0, 6'd3, 8'h8D);
        wr(1, 1'b1, 6'd0, 8'hC6);
        wr(1, 1'b1, 6'd1, 8'h39);
        wr(1, 1'b1, 6'd2, 8'hA5);
        wr(1, 1'b1, 6'd3, 8'h5A);
        wr(1, 1'b0, 6'd4, 8'hFF);
        wr(1, 1'b1, 6'd63, 8'hFF);
        run(1, 1, 12'h7AA, -1, -1, -1, 1'b0, 8'h00);
        run(1, -1, 12'h000, -1, -1, -1, 1'b0, 8'h00);
        check("error_held", error_v[1], 1);
        check("timeout_result_held", result_v[1], 0);
        run(1, 2, 12'h055, -1, -1, -1, 1'b0, 8'h00);
        check("result_held", result_v[1], 12'h055);

        check("beat_queue_drained", beat_q.size(), 0);
        check("done_queue_drained", end_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_feeder.md
SW_FEEDER -- requirements
Module: sw_feeder

Interface
REQ-001 Parameter: SEQ_LEN, 256, bases per sequence; a multiple of 4 in the range 4..256.
REQ-002 Parameter: TIMEOUT, 4095, maximum WAIT-state cycles before abort; 1..4095.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: wr_en  input  1  host write strobe into sequence storage.
REQ-006 Port: wr_sel  input  1  target store; 0 selects S, 1 selects T.
REQ-007 Port: wr_addr  input  6  byte address; byte a holds bases 4a..4a+3.
REQ-008 Port: wr_data  input  8  four packed bases; base 4a+k in bits [2k+1:2k].
REQ-009 Port: start  input  1  one-cycle request to run one alignment.
REQ-010 Port: busy  output  1  high while not in IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: error  output  1  timeout flag; valid in the done cycle and held until next start.
REQ-013 Port: result  output  12  captured alignment score.
REQ-014 Port: valid  output  1  to aligner; high for exactly SEQ_LEN consecutive cycles per run.
REQ-015 Port: data_s  output  2  S base to aligner.
REQ-016 Port: data_t  output  2  T base to aligner.
REQ-017 Port: finish  input  1  aligner completion.
REQ-018 Port: max  input  12  aligner score; sampled when finish=1.

Function
REQ-019 Storage shall be two SEQ_LEN x 2-bit arrays (S, T), written only when wr_en=1, state=IDLE and wr_addr < SEQ_LEN/4; all other writes are dropped.
REQ-020 FSM states shall be IDLE, STREAM, WAIT, DONE.
REQ-021 IDLE -> STREAM shall occur on the clock edge that samples start=1; start outside IDLE is ignored.
REQ-022 If wr_en and start are both high in IDLE, the write shall complete and streaming shall use the updated data.
REQ-023 In STREAM, valid, data_s and data_t shall be registered outputs; the cycle after start is sampled drives index 0, and each following cycle increments the index by 1.
REQ-024 After index SEQ_LEN-1 is driven, the next cycle shall enter WAIT with valid=0, data_s=0, data_t=0.
REQ-025 Whenever valid=0, data_s and data_t shall be 0.
REQ-026 finish shall be ignored in IDLE, STREAM and DONE.
REQ-027 In WAIT, a 12-bit counter shall start at 0 and increment each cycle; finish=1 captures max into result, clears error, and moves to DONE.
REQ-028 If the counter reaches TIMEOUT-1 without finish, result shall be set to 0, error set to 1, and the FSM moves to DONE; finish in that same cycle takes priority (normal capture).
REQ-029 DONE shall last exactly one cycle with done=1, then return to IDLE.
REQ-030 error shall be cleared when start is accepted.
REQ-031 busy shall be 1 in STREAM, WAIT and DONE.
REQ-032 result shall hold its value until the next capture or timeout.

Reset
REQ-033 Asserting reset shall force IDLE and set valid=0, data_s=0, data_t=0, busy=0, done=0, error=0, result=0, and clear both counters, regardless of state.
REQ-034 Sequence storage shall not be cleared by reset.
REQ-035 Reset asserted mid-STREAM shall abort the run with no done pulse; a new start is required.

Verification
REQ-036 Load S=all 0, T=all 0 (64 writes each), start; max=12'd512 with finish after 20 WAIT cycles -> exactly 256 valid cycles with data 0, then done=1 for one cycle, result=512, error=0.
REQ-037 Load S byte0=8'hE4 (bases 0,1,2,3), start -> data_s sequence begins 0,1,2,3 on the first four valid cycles; compare all 256 bases with the loaded image.
REQ-038 finish held at 0 with TIMEOUT=16 -> done exactly 16 cycles after WAIT entry, error=1, result=0; next start clears error.
REQ-039 Pulse finish=1 during STREAM with max=12'hFFF -> no capture and no done; the stream runs the full 256 cycles.
REQ-040 Assert reset at stream index 100 -> valid=0 and busy=0 immediately (asynchronous), no done pulse; restart produces the full 256-cycle stream.
REQ-041 wr_en with data 8'hFF during STREAM, and start during WAIT -> storage unchanged and run timing unaffected, checked on a second run.
